hs_lane_arbiter: RTL and testbench
==================================

# hs_lane_arbiter

- Packet-level round-robin arbiter that shares one hardware-subunit input buffer path between the four input lane routers.
- Grants one lane at a time and holds the grant until that lane's end-of-packet beat has been forwarded.
- Forwards the granted lane's 35-bit words through one output register stage under valid/ready flow control.
- Sits between the lane routers and each high-speed buffer / hardware subunit pair, and also serves as the scheduler for the output lane buffers.

## Interface
Parameters:
- NUM_REQ, 4: number of requesting lanes. Fixed at 4; grant_id is 2 bits.
- DATA_W, 35: word width. Bits [31:0] are payload, [33:32] are the destination subunit id, [34] is the end-of-packet (EOP) flag.
- MAX_BURST, 16: maximum number of beats one grant may hold.

Ports:
- clk, in, 1: single clock for the block.
- reset, in, 1: reset is synchronous and active-high.
- req_valid, in, 4: per-lane word valid.
- req_data0..req_data3, in, 35 each: per-lane word.
- req_ready, out, 4: per-lane accept. A beat transfers when req_valid[i] and req_ready[i] are both high.
- lane_mask, in, 4: lane enable; 1 means the lane is eligible for a grant.
- out_valid, out, 1: output register holds a word.
- out_data, out, 35: registered forwarded word.
- out_ready, in, 1: downstream accept.
- grant_id, out, 2: lane currently holding the grant. Valid while busy is high.
- busy, out, 1: high while in GRANTED.
- overrun, out, 1: sticky flag, set when a grant was force-released at MAX_BURST. Cleared only by reset.

## Operation
- State IDLE:
  - req_ready = 0.
  - Eligible lanes are those with req_valid[i] and lane_mask[i] high.
  - The winner is the first eligible lane searching upward from rr_ptr, modulo 4.
  - If a winner exists, register grant_id = winner and go to GRANTED. Otherwise stay in IDLE.
- State GRANTED:
  - req_ready[grant_id] = !out_valid || out_ready. All other req_ready bits are 0.
  - On each transfer, load the word into out_data, set out_valid, and increment beat_cnt (5 bits).
  - Release when the transferred word has bit 34 = 1, or when beat_cnt reaches MAX_BURST. A MAX_BURST release also sets overrun.
  - On release: go to IDLE, set rr_ptr = grant_id + 1 (mod 4), clear beat_cnt.
- Output register:
  - Cleared (out_valid = 0) when out_ready is high and no new beat loads in the same cycle.
  - Holds its contents while out_valid && !out_ready.
- lane_mask changes:
  - A change has no effect on an active grant.
  - It is sampled only in IDLE.
- A lane that drops req_valid mid-packet keeps the grant. The arbiter waits indefinitely; there is no timeout.
- The destination field [33:32] passes through unmodified. It is not interpreted by this block.

## Timing
- Reset values:
  - out_valid = 0, out_data = 0, req_ready = 0, grant_id = 0, busy = 0, overrun = 0.
  - rr_ptr = 0, beat_cnt = 0, state = IDLE.
- Reset asserted mid-packet:
  - In-flight data is discarded.
  - All outputs take their reset values at the next edge.
- Arbitration latency:
  - Request first seen at cycle N in IDLE.
  - Grant is registered at edge N+1.
  - req_ready rises in cycle N+1.
  - First word appears on out_data in cycle N+2.
- Throughput: 1 beat per cycle while out_ready is held high.
- Inter-packet gap: exactly 1 IDLE cycle after an EOP transfer before the next grant, including back-to-back requests from the same lane.
- Simultaneous load and drain: when out_ready is high and a new beat transfers in the same cycle, out_valid stays high and out_data updates.
- rr_ptr wraps from 3 to 0.
- When every requesting lane is masked, the block stays in IDLE with busy = 0.

## Structure
- Shared package contents:
  - DATA_W.
  - EOP_BIT = 34.
  - DEST_MSB/DEST_LSB = 33/32.
  - NUM_REQ.
  - MAX_BURST default.
  - State enum {IDLE, GRANTED}.
- Sub-module rr_picker:
  - Purely combinational.
  - Inputs: 4-bit eligible vector, 2-bit rr_ptr.
  - Outputs: found flag, 2-bit winner.
  - Reused by the output lane buffer scheduler.
- The top file holds the FSM, beat counter, output register and req_ready decode.

## Test plan
- Single packet, no contention:
  - Stimulus: lane 2 sends 3 beats, the last with bit 34 = 1; out_ready held at 1.
  - Required: grant_id = 2; words appear on out_data in cycles 2–4; rr_ptr becomes 3; busy falls after the EOP transfer.
- Round-robin ordering:
  - Stimulus: all four lanes send 1-beat packets continuously, starting from reset.
  - Required: grant order 0, 1, 2, 3, 0, with one idle cycle between grants.
- Backpressure:
  - Stimulus: out_ready held at 0 for 5 cycles mid-packet.
  - Required: out_data stable, req_ready[g] = 0 during the stall, no beat lost or duplicated.
- Mask:
  - Stimulus: lane_mask = 4'b1010 with all lanes requesting.
  - Required: only lanes 1 and 3 are granted, alternating.
  - Stimulus: clear lane_mask[1] mid-packet on lane 1.
  - Required: that packet completes.
- Overrun:
  - Stimulus: lane 0 sends 20 beats with no EOP.
  - Required: release after beat 16, overrun = 1, and lane 1 is granted next if it is requesting.
- Reset mid-packet:
  - Stimulus: assert reset during beat 2 of 4.
  - Required: out_valid = 0, busy = 0, rr_ptr = 0 at the next edge; the first request after reset is granted lane 0-first.

Source files
------------

// File: rtl/hs_lane_arbiter_pkg.sv
// Shared constants and types for the packet-level lane arbiter and its
// round-robin picker.
package hs_lane_arbiter_pkg;
   localparam int NUM_REQ       = 4;
   localparam int DATA_W        = 35;
   localparam int EOP_BIT       = 34;
   localparam int DEST_MSB      = 33;
   localparam int DEST_LSB      = 32;
   localparam int MAX_BURST_DEF = 16;
   localparam int CNT_W         = 5;
   localparam int ID_W          = 2;

   typedef enum logic {
      IDLE    = 1'b0,
      GRANTED = 1'b1
   } state_e;
endpackage

// File: rtl/hs_lane_arbiter_if.sv
// Lane-side request bus and forwarded-word bus of the lane arbiter.
interface hs_lane_arbiter_if;
   import hs_lane_arbiter_pkg::*;

   logic [NUM_REQ-1:0] req_valid;
   logic [DATA_W-1:0]  req_data0;
   logic [DATA_W-1:0]  req_data1;
   logic [DATA_W-1:0]  req_data2;
   logic [DATA_W-1:0]  req_data3;
   logic [NUM_REQ-1:0] req_ready;
   logic [NUM_REQ-1:0] lane_mask;
   logic               out_valid;
   logic [DATA_W-1:0]  out_data;
   logic               out_ready;
   logic [ID_W-1:0]    grant_id;
   logic               busy;
   logic               overrun;

   modport master (
      output req_valid, req_data0, req_data1, req_data2, req_data3, lane_mask, out_ready,
      input  req_ready, out_valid, out_data, grant_id, busy, overrun
   );

   modport slave (
      input  req_valid, req_data0, req_data1, req_data2, req_data3, lane_mask, out_ready,
      output req_ready, out_valid, out_data, grant_id, busy, overrun
   );
endinterface

// File: rtl/hs_lane_arbiter_rr_picker.sv
// Combinational round-robin picker: first eligible lane at or above the
// pointer, wrapping modulo NUM_REQ.
module hs_lane_arbiter_rr_picker
   import hs_lane_arbiter_pkg::*;
(
   input  logic [NUM_REQ-1:0] i_eligible,
   input  logic [ID_W-1:0]    i_rr_ptr,
   output logic               o_found,
   output logic [ID_W-1:0]    o_winner
);
   logic [ID_W-1:0] w_idx;

   always_comb begin
      o_found  = 1'b0;
      o_winner = '0;
      w_idx    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_idx = i_rr_ptr + ID_W'(k);
         if (!o_found && i_eligible[w_idx]) begin
            o_found  = 1'b1;
            o_winner = w_idx;
         end
      end
   end
endmodule

// File: rtl/hs_lane_arbiter.sv
// Packet-level round-robin arbiter: grants one lane until its EOP (or the
// burst limit) and forwards its words through one output register.
module hs_lane_arbiter
   import hs_lane_arbiter_pkg::*;
#(
   parameter int MAX_BURST = MAX_BURST_DEF
) (
   input  logic             clk,
   input  logic             reset,
   hs_lane_arbiter_if.slave bus
);
   state_e               r_state;
   state_e               w_state_nxt;
   logic [ID_W-1:0]      r_grant_id;
   logic [ID_W-1:0]      r_rr_ptr;
   logic [CNT_W-1:0]     r_beat_cnt;
   logic                 r_out_valid;
   logic [DATA_W-1:0]    r_out_data;
   logic                 r_overrun;

   logic [NUM_REQ-1:0]   w_eligible;
   logic                 w_found;
   logic [ID_W-1:0]      w_winner;
   logic [DATA_W-1:0]    w_sel_data;
   logic                 w_slot_free;
   logic                 w_xfer;
   logic [CNT_W-1:0]     w_beat_inc;
   logic                 w_burst_end;
   logic                 w_eop;
   logic                 w_release;
   logic                 w_busy;
   logic [NUM_REQ-1:0]   w_req_ready;

   // lane_mask only matters here, i.e. while choosing a new owner
   assign w_eligible = bus.req_valid & bus.lane_mask;

   hs_lane_arbiter_rr_picker u_picker (
      .i_eligible (w_eligible),
      .i_rr_ptr   (r_rr_ptr),
      .o_found    (w_found),
      .o_winner   (w_winner)
   );

   always_comb begin
      w_sel_data = '0;
      case (r_grant_id)
         2'd0:    w_sel_data = bus.req_data0;
         2'd1:    w_sel_data = bus.req_data1;
         2'd2:    w_sel_data = bus.req_data2;
         default: w_sel_data = bus.req_data3;
      endcase
   end

   assign w_slot_free = !r_out_valid || bus.out_ready;
   assign w_xfer      = (r_state == GRANTED) && w_slot_free && bus.req_valid[r_grant_id];
   assign w_beat_inc  = r_beat_cnt + CNT_W'(1);
   assign w_burst_end = (w_beat_inc == CNT_W'(MAX_BURST));
   assign w_eop       = w_sel_data[EOP_BIT];
   assign w_release   = w_xfer && (w_eop || w_burst_end);

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_busy      = 1'b0;
      w_req_ready = '0;
      case (r_state)
         IDLE: begin
            if (w_found) w_state_nxt = GRANTED;
         end
         GRANTED: begin
            w_busy                  = 1'b1;
            w_req_ready[r_grant_id] = w_slot_free;
            if (w_release) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_grant_id  <= '0;
         r_rr_ptr    <= '0;
         r_beat_cnt  <= '0;
         r_overrun   <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else begin
         if ((r_state == IDLE) && w_found) r_grant_id <= w_winner;
         if (w_xfer) begin
            if (w_release) begin
               r_beat_cnt <= '0;
               r_rr_ptr   <= r_grant_id + ID_W'(1);
               if (w_burst_end && !w_eop) r_overrun <= 1'b1;
            end else begin
               r_beat_cnt <= w_beat_inc;
            end
         end
         // a new beat wins over draining, so load+drain keeps out_valid high
         if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_sel_data;
         end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign bus.req_ready = w_req_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.grant_id  = r_grant_id;
   assign bus.busy      = w_busy;
   assign bus.overrun   = r_overrun;
endmodule

// File: tb/tb_hs_lane_arbiter.sv
// Scoreboard bench for hs_lane_arbiter: lane sources feed per-lane queues,
// accepted beats are queued as expected output and compared on drain.
module tb_hs_lane_arbiter;
   import hs_lane_arbiter_pkg::*;

   logic clk;
   logic reset;

   hs_lane_arbiter_if bus ();

   hs_lane_arbiter dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int vectors    = 0;
   int miscompares = 0;
   int cyc        = 0;

   logic [DATA_W-1:0] lane_q [4][$];
   logic [DATA_W-1:0] sb_q [$];
   int grant_log [$];
   int grant_cyc [$];
   int out_cyc [$];
   int hs_lane [$];
   bit hs_pend [4];
   bit prev_busy;

   function automatic logic [DATA_W-1:0] mk_word(input logic eop, input logic [1:0] lane,
                                                  input logic [15:0] idx);
      return {eop, lane, 16'hC0DE, idx};
   endfunction

   // Lane sources drive on the falling edge; handshakes and output drains
   // are observed 1 time unit later, ahead of the rising edge that commits them.
   initial begin : engine
      logic [DATA_W-1:0] drv [4];
      logic [DATA_W-1:0] exp_w;
      bus.req_valid = '0;
      bus.req_data0 = '0;
      bus.req_data1 = '0;
      bus.req_data2 = '0;
      bus.req_data3 = '0;
      prev_busy     = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         for (int i = 0; i < 4; i++) begin
            if (hs_pend[i]) begin
               if (lane_q[i].size() > 0) void'(lane_q[i].pop_front());
               hs_pend[i] = 1'b0;
            end
            bus.req_valid[i] = (lane_q[i].size() > 0);
            drv[i] = (lane_q[i].size() > 0) ? lane_q[i][0] : '0;
         end
         bus.req_data0 = drv[0];
         bus.req_data1 = drv[1];
         bus.req_data2 = drv[2];
         bus.req_data3 = drv[3];
         #1;
         if (reset) begin
            prev_busy = 1'b0;
         end else begin
            for (int i = 0; i < 4; i++) begin
               if (bus.req_valid[i] && bus.req_ready[i]) begin
                  hs_pend[i] = 1'b1;
                  sb_q.push_back(drv[i]);
                  hs_lane.push_back(i);
               end
            end
            if (bus.busy && !prev_busy) begin
               grant_log.push_back(int'(bus.grant_id));
               grant_cyc.push_back(cyc);
            end
            prev_busy = bus.busy;
            if (bus.out_valid && bus.out_ready) begin
               vectors++;
               if (sb_q.size() == 0) begin
                  miscompares++;
                  $display("FAIL sb_unexpected: got %h required no word", bus.out_data);
               end else begin
                  exp_w = sb_q.pop_front();
                  if (bus.out_data !== exp_w) begin
                     miscompares++;
                     $display("FAIL sb_data: got %h required %h", bus.out_data, exp_w);
                  end
               end
               out_cyc.push_back(cyc);
            end
         end
      end
   end

   task automatic flush_all();
      for (int i = 0; i < 4; i++) lane_q[i].delete();
      sb_q.delete();
      grant_log.delete();
      grant_cyc.delete();
      out_cyc.delete();
      hs_lane.delete();
   endtask

   task automatic do_reset();
      @(posedge clk); #2;
      reset = 1'b1;
      bus.out_ready = 1'b1;
      bus.lane_mask = 4'hF;
      repeat (2) @(posedge clk);
      #2;
      flush_all();
      reset = 1'b0;
   endtask

   task automatic wait_drain(input int budget, output bit ok);
      bit empty;
      ok = 1'b0;
      for (int c = 0; c < budget; c++) begin
         @(posedge clk); #2;
         empty = (sb_q.size() == 0) && !bus.busy;
         for (int i = 0; i < 4; i++) if (lane_q[i].size() > 0) empty = 1'b0;
         if (empty) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_outs(input int n, input int budget, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < budget; c++) begin
         @(posedge clk); #2;
         if (out_cyc.size() >= n) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #2;
      vectors += 7;
      if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %b required 0", bus.out_valid); end
      if (bus.out_data !== '0) begin miscompares++; $display("FAIL rst_out_data: got %h required 0", bus.out_data); end
      if (bus.req_ready !== 4'h0) begin miscompares++; $display("FAIL rst_req_ready: got %b required 0000", bus.req_ready); end
      if (bus.grant_id !== 2'd0) begin miscompares++; $display("FAIL rst_grant_id: got %0d required 0", bus.grant_id); end
      if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b required 0", bus.busy); end
      if (bus.overrun !== 1'b0) begin miscompares++; $display("FAIL rst_overrun: got %b required 0", bus.overrun); end
      if (dut.r_rr_ptr !== 2'd0) begin miscompares++; $display("FAIL rst_rr_ptr: got %0d required 0", dut.r_rr_ptr); end
      reset = 1'b0;
   endtask

   task automatic test_single_packet();
      bit ok;
      int req_n;
      do_reset();
      for (int b = 0; b < 3; b++) lane_q[2].push_back(mk_word(b == 2, 2'd2, 16'(b)));
      req_n = cyc + 1;
      wait_drain(40, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL single_drain: got timeout required drain"); end
      vectors++;
      if (grant_log.size() != 1 || grant_log[0] != 2) begin
         miscompares++; $display("FAIL single_grant: got %0d grants first=%0d required 1 grant of lane 2",
                                 grant_log.size(), (grant_log.size() > 0) ? grant_log[0] : -1);
      end
      vectors++;
      if (grant_cyc.size() < 1 || grant_cyc[0] != req_n + 1) begin
         miscompares++; $display("FAIL single_grant_cycle: got %0d required %0d",
                                 (grant_cyc.size() > 0) ? grant_cyc[0] : -1, req_n + 1);
      end
      for (int k = 0; k < 3; k++) begin
         vectors++;
         if (out_cyc.size() <= k || out_cyc[k] != req_n + 2 + k) begin
            miscompares++; $display("FAIL single_out_cycle%0d: got %0d required %0d", k,
                                    (out_cyc.size() > k) ? out_cyc[k] : -1, req_n + 2 + k);
         end
      end
      vectors += 2;
      if (dut.r_rr_ptr !== 2'd3) begin miscompares++; $display("FAIL single_rr_ptr: got %0d required 3", dut.r_rr_ptr); end
      if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL single_busy: got %b required 0", bus.busy); end
   endtask

   task automatic test_back_to_back();
      bit ok;
      do_reset();
      for (int p = 0; p < 2; p++)
         for (int b = 0; b < 2; b++) lane_q[0].push_back(mk_word(b == 1, 2'd0, 16'(p * 2 + b)));
      wait_drain(40, ok);
      vectors += 3;
      if (!ok) begin miscompares++; $display("FAIL b2b_drain: got timeout required drain"); end
      if (out_cyc.size() != 4) begin miscompares++; $display("FAIL b2b_count: got %0d required 4", out_cyc.size()); end
      if (grant_cyc.size() != 2 || grant_cyc[1] - grant_cyc[0] != 3) begin
         miscompares++; $display("FAIL b2b_gap: got %0d grants spacing %0d required 2 grants spacing 3",
                                 grant_cyc.size(), (grant_cyc.size() > 1) ? grant_cyc[1] - grant_cyc[0] : -1);
      end
   endtask

   task automatic test_round_robin();
      bit ok;
      int exp_order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
      do_reset();
      for (int i = 0; i < 4; i++)
         for (int p = 0; p < 2; p++) lane_q[i].push_back(mk_word(1'b1, 2'(i), 16'(p)));
      wait_drain(80, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL rr_drain: got timeout required drain"); end
      for (int k = 0; k < 8; k++) begin
         vectors++;
         if (grant_log.size() <= k || grant_log[k] != exp_order[k]) begin
            miscompares++; $display("FAIL rr_order%0d: got %0d required %0d", k,
                                    (grant_log.size() > k) ? grant_log[k] : -1, exp_order[k]);
         end
      end
      for (int k = 1; k < 8; k++) begin
         vectors++;
         if (grant_cyc.size() <= k || grant_cyc[k] - grant_cyc[k-1] != 2) begin
            miscompares++; $display("FAIL rr_gap%0d: got %0d required 2", k,
                                    (grant_cyc.size() > k) ? grant_cyc[k] - grant_cyc[k-1] : -1);
         end
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      logic [DATA_W-1:0] held;
      do_reset();
      for (int b = 0; b < 6; b++) lane_q[1].push_back(mk_word(b == 5, 2'd1, 16'(16'h100 + b)));
      wait_outs(2, 40, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL bp_start: got timeout required 2 words"); end
      bus.out_ready = 1'b0;
      held = bus.out_data;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #2;
         vectors += 3;
         if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid%0d: got %b required 1", k, bus.out_valid); end
         if (bus.out_data !== held) begin miscompares++; $display("FAIL bp_data%0d: got %h required %h", k, bus.out_data, held); end
         if (bus.req_ready !== 4'h0) begin miscompares++; $display("FAIL bp_ready%0d: got %b required 0000", k, bus.req_ready); end
      end
      bus.out_ready = 1'b1;
      wait_drain(40, ok);
      vectors += 2;
      if (!ok) begin miscompares++; $display("FAIL bp_drain: got timeout required drain"); end
      if (out_cyc.size() != 6) begin miscompares++; $display("FAIL bp_count: got %0d required 6", out_cyc.size()); end
   endtask

   task automatic test_mask();
      bit ok;
      int exp_order [4] = '{1, 3, 1, 3};
      do_reset();
      bus.lane_mask = 4'b1010;
      for (int i = 0; i < 4; i++)
         for (int p = 0; p < 2; p++) lane_q[i].push_back(mk_word(1'b1, 2'(i), 16'(16'h200 + p)));
      for (int c = 0; c < 60 && grant_log.size() < 4; c++) begin
         @(posedge clk); #2;
      end
      for (int k = 0; k < 4; k++) begin
         vectors++;
         if (grant_log.size() <= k || grant_log[k] != exp_order[k]) begin
            miscompares++; $display("FAIL mask_order%0d: got %0d required %0d", k,
                                    (grant_log.size() > k) ? grant_log[k] : -1, exp_order[k]);
         end
      end
      lane_q[0].delete();
      lane_q[2].delete();
      wait_drain(40, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL mask_drain1: got timeout required drain"); end
      for (int b = 0; b < 4; b++) lane_q[1].push_back(mk_word(b == 3, 2'd1, 16'(16'h300 + b)));
      wait_outs(5, 40, ok);
      bus.lane_mask = 4'b0000;
      lane_q[3].push_back(mk_word(1'b1, 2'd3, 16'h0400));
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL mask_midpkt_start: got timeout required first word"); end
      wait_outs(8, 40, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL mask_midpkt_complete: got %0d words required 8", out_cyc.size()); end
      repeat (5) @(posedge clk);
      #2;
      vectors += 2;
      if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL mask_all_off_busy: got %b required 0", bus.busy); end
      if (grant_log.size() != 5) begin miscompares++; $display("FAIL mask_all_off_grants: got %0d required 5", grant_log.size()); end
      bus.lane_mask = 4'hF;
      wait_drain(40, ok);
      vectors++;
      if (!ok || grant_log.size() != 6 || grant_log[5] != 3) begin
         miscompares++; $display("FAIL mask_reenable: got %0d grants required lane 3 as 6th", grant_log.size());
      end
   endtask

   task automatic test_overrun();
      bit ok;
      do_reset();
      for (int b = 0; b < 20; b++) lane_q[0].push_back(mk_word(1'b0, 2'd0, 16'(16'h500 + b)));
      lane_q[1].push_back(mk_word(1'b1, 2'd1, 16'h0600));
      wait_outs(21, 100, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL ovr_progress: got %0d words required 21", out_cyc.size()); end
      for (int k = 0; k < 18; k++) begin
         vectors++;
         if (hs_lane.size() <= k || hs_lane[k] != ((k == 16) ? 1 : 0)) begin
            miscompares++; $display("FAIL ovr_beat_lane%0d: got %0d required %0d", k,
                                    (hs_lane.size() > k) ? hs_lane[k] : -1, (k == 16) ? 1 : 0);
         end
      end
      vectors += 2;
      if (bus.overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_flag: got %b required 1", bus.overrun); end
      if (grant_log.size() < 2 || grant_log[1] != 1) begin
         miscompares++; $display("FAIL ovr_next_grant: got %0d required 1",
                                 (grant_log.size() > 1) ? grant_log[1] : -1);
      end
   endtask

   task automatic test_reset_mid_packet();
      bit ok;
      do_reset();
      lane_q[2].push_back(mk_word(1'b1, 2'd2, 16'h0700));
      wait_drain(40, ok);
      for (int b = 0; b < 4; b++) lane_q[3].push_back(mk_word(b == 3, 2'd3, 16'(16'h800 + b)));
      wait_outs(2, 40, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL rmid_start: got timeout required beat 1"); end
      reset = 1'b1;
      @(posedge clk); #2;
      vectors += 5;
      if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_out_valid: got %b required 0", bus.out_valid); end
      if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rmid_busy: got %b required 0", bus.busy); end
      if (dut.r_rr_ptr !== 2'd0) begin miscompares++; $display("FAIL rmid_rr_ptr: got %0d required 0", dut.r_rr_ptr); end
      if (bus.req_ready !== 4'h0) begin miscompares++; $display("FAIL rmid_req_ready: got %b required 0000", bus.req_ready); end
      if (bus.out_data !== '0) begin miscompares++; $display("FAIL rmid_out_data: got %h required 0", bus.out_data); end
      flush_all();
      reset = 1'b0;
      lane_q[3].push_back(mk_word(1'b1, 2'd3, 16'h0900));
      lane_q[0].push_back(mk_word(1'b1, 2'd0, 16'h0901));
      wait_drain(40, ok);
      vectors += 2;
      if (!ok) begin miscompares++; $display("FAIL rmid_drain: got timeout required drain"); end
      if (grant_log.size() != 2 || grant_log[0] != 0 || grant_log[1] != 3) begin
         miscompares++; $display("FAIL rmid_order: got first=%0d second=%0d required 0 then 3",
                                 (grant_log.size() > 0) ? grant_log[0] : -1,
                                 (grant_log.size() > 1) ? grant_log[1] : -1);
      end
   endtask

   initial begin
      reset         = 1'b1;
      bus.out_ready = 1'b1;
      bus.lane_mask = 4'hF;
      test_reset();
      test_single_packet();
      test_back_to_back();
      test_round_robin();
      test_backpressure();
      test_mask();
      test_overrun();
      test_reset_mid_packet();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
